// File: rtl/adc_bcd_reader.sv
// Reads a 12-bit code from a serial ADC, scales it to millivolts and emits four ASCII digits.
// Define ADC_AVG_EN to average four back-to-back frames before scaling.
module adc_bcd_reader #(
  parameter int SCLK_DIV = 50,
  parameter int VREF_MV  = 3300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miso,
  input  logic        bcd_start,
  output logic        bcd_end,
  output logic [31:0] BCD_converted_num,
  output logic        ss,
  output logic        sclk,
  output logic [7:0]  leds
);

  localparam int CW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    QUIET,
    SCALE,
    DABBLE,
    DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_divCnt;
  logic [4:0]    r_bitCnt;
  // Only the low 12 bits of the frame matter; the four leading zeros shift out the top.
  logic [11:0]   r_shreg;
  logic [27:0]   r_dab;
  logic [3:0]    r_dabCnt;
`ifdef ADC_AVG_EN
  logic [13:0]   r_acc;
  logic [1:0]    r_frameCnt;
`endif

  logic [11:0]   w_code;
  logic [23:0]   w_product;
  logic [11:0]   w_mv;
  logic [27:0]   w_dabAdj;
  logic [27:0]   w_dabNext;
  logic [31:0]   w_ascii;

`ifdef ADC_AVG_EN
  assign w_code = 12'(r_acc >> 2);
`else
  assign w_code = r_shreg;
`endif

  assign w_product = {12'd0, w_code} * 24'(VREF_MV);
  assign w_mv      = 12'(w_product >> 12);

  // One double-dabble step: correct each BCD digit that would overflow, then shift left.
  always_comb begin
    w_dabAdj = r_dab;
    for (int i = 0; i < 4; i++) begin
      if (r_dab[12+4*i +: 4] >= 4'd5) begin
        w_dabAdj[12+4*i +: 4] = r_dab[12+4*i +: 4] + 4'd3;
      end
    end
    w_dabNext = w_dabAdj << 1;
  end

  assign w_ascii = {4'h3, w_dabNext[27:24], 4'h3, w_dabNext[23:20],
                    4'h3, w_dabNext[19:16], 4'h3, w_dabNext[15:12]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_divCnt          <= '0;
      r_bitCnt          <= '0;
      r_shreg           <= '0;
      r_dab             <= '0;
      r_dabCnt          <= '0;
`ifdef ADC_AVG_EN
      r_acc             <= '0;
      r_frameCnt        <= '0;
`endif
      ss                <= 1'b1;
      sclk              <= 1'b1;
      bcd_end           <= 1'b0;
      leds              <= '0;
      BCD_converted_num <= 32'h30303030;
    end else begin
      bcd_end <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bcd_start) begin
            ss       <= 1'b0;
            r_divCnt <= '0;
            r_bitCnt <= '0;
`ifdef ADC_AVG_EN
            r_acc      <= '0;
            r_frameCnt <= '0;
`endif
            r_state  <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
            sclk     <= 1'b0;
            r_state  <= SHIFT;
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        // Each half-period ends on DIV_LAST; a low half ends with the rising edge and the sample.
        SHIFT: begin
          if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
            if (!sclk) begin
              sclk     <= 1'b1;
              r_shreg  <= {r_shreg[10:0], miso};
              r_bitCnt <= r_bitCnt + 1'b1;
            end else if (r_bitCnt == 5'd16) begin
              ss      <= 1'b1;
`ifdef ADC_AVG_EN
              r_acc   <= r_acc + {2'b00, r_shreg};
`endif
              r_state <= QUIET;
            end else begin
              sclk <= 1'b0;
            end
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        QUIET: begin
          if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
`ifdef ADC_AVG_EN
            if (r_frameCnt != 2'd3) begin
              r_frameCnt <= r_frameCnt + 1'b1;
              r_bitCnt   <= '0;
              ss         <= 1'b0;
              r_state    <= CS_SETUP;
            end else begin
              r_state <= SCALE;
            end
`else
            r_state <= SCALE;
`endif
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        SCALE: begin
          r_dab    <= {16'd0, w_mv};
          r_dabCnt <= '0;
          r_state  <= DABBLE;
        end

        // The final shift's result goes straight to the outputs so DONE lasts a single cycle.
        DABBLE: begin
          r_dab <= w_dabNext;
          if (r_dabCnt == 4'd11) begin
            bcd_end           <= 1'b1;
            BCD_converted_num <= w_ascii;
            leds              <= w_code[11:4];
            r_state           <= DONE;
          end else begin
            r_dabCnt <= r_dabCnt + 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
